// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- byte stream interface between uart_rx and its consumer.
//
// Signals:
//   m_data  [7:0]  received byte (driven by the receiver)
//   m_valid        high while m_data holds an unconsumed byte
//   m_ready        consumer acceptance
//
// Handshake: a transfer happens on a rising clk edge where m_valid and
// m_ready are both high. While m_valid is high, m_data does not change
// until that transfer edge. m_ready may be driven independently of m_valid.
//
// Modports:
//   master -- the receiver (drives m_data/m_valid, reads m_ready)
//   slave  -- the consumer (reads m_data/m_valid, drives m_ready)
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 16x oversampling UART receiver, 8N1 (8E1 with parity enabled).
//
// Parameters:
//   CLK_HZ  clock frequency in Hz
//   BAUD    serial bit rate
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   rxd          serial input, asynchronous to clk, idle high
//   m_if         uart_rx_if.master: m_data / m_valid / m_ready byte stream
//   frame_err    one-cycle pulse when the stop bit samples low
//   overrun      one-cycle pulse when a byte is dropped (holding reg full)
//   parity_err   one-cycle pulse on even-parity mismatch (parity build only)
//   dbg_state_o  current FSM state encoding (0 IDLE, 1 START, 2 DATA,
//                3 STOP, 4 PARITY)
//
// Build option:
//   UART_RX_PARITY_EN -- when defined, a PARITY state sits between DATA and
//   STOP, even parity is checked over the 8 data bits plus the parity bit,
//   and the parity_err port exists.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    uart_rx_if.master  m_if,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic [2:0] dbg_state_o
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic [1:0]    arm_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic          parity_q, parity_d;
    logic          parity_err_q, parity_err_d;
`endif

    logic tick, fall, hs, stop_eval, frame_bad, par_bad;

    // Synchronizer plus edge-detect history. arm_q fills with ones over the
    // two cycles the synchronizer needs to flush its reset value; until then
    // rxd_prev_q is held low, so a line that is already low when reset
    // releases cannot be mistaken for a fresh 1->0 start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b0;
            arm_q      <= 2'b00;
        end else begin
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            arm_q      <= {arm_q[0], 1'b1};
            rxd_prev_q <= arm_q[1] ? rxd_s2_q : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_d     = parity_q;
        parity_err_d = 1'b0;
`endif
        stop_eval = 1'b0;
        frame_bad = 1'b0;
        par_bad   = 1'b0;

        tick = (tick_cnt_q == TW'(DIV - 1));
        fall = rxd_prev_q & ~rxd_s2_q;
        hs   = valid_q & m_if.m_ready;

        if (hs) valid_d = 1'b0;

        // Oversampling counters run only inside a frame; samp_cnt wraps
        // naturally every 16 ticks, which is one bit period.
        if (state_q != S_IDLE) tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        if (tick) samp_cnt_d = samp_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                if (fall) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick && samp_cnt_q == 4'd7) begin
                    samp_cnt_d = '0;
                    state_d    = rxd_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && samp_cnt_q == 4'd15) begin
                    shift_d   = {rxd_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick && samp_cnt_q == 4'd15) begin
                    parity_d = rxd_s2_q;
                    state_d  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick && samp_cnt_q == 4'd15) begin
                    stop_eval = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop_eval) begin
            frame_bad   = ~rxd_s2_q;
            frame_err_d = frame_bad;
`ifdef UART_RX_PARITY_EN
            par_bad      = ^{shift_q, parity_q};
            parity_err_d = par_bad;
`endif
            if (!frame_bad && !par_bad) begin
                // A byte completing on the handshake edge replaces the
                // departing one; otherwise a full holding register drops it.
                if (valid_q && !hs) begin
                    overrun_d = 1'b1;
                end else begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end
            end
        end
    end

    assign m_if.m_data  = data_q;
    assign m_if.m_valid = valid_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`endif
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx.
// Runs the receiver at CLK_HZ=16 MHz, BAUD=115200: DIV = 8 (8.68 truncated),
// so one bit is 128 clocks and the stop-bit midpoint falls 9.5 bits = 1216
// clocks after the start edge, plus 2-3 clocks of synchronizer delay.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    localparam int CLK_HZ = 16000000;
    localparam int BAUD   = 115200;
    localparam int DIV    = CLK_HZ / (BAUD * 16);
    localparam int BIT    = DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic       frame_err;
    logic       overrun;
    logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_if m_if ();

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .m_if        (m_if),
        .frame_err   (frame_err),
        .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    int valid_cycles = 0;
    int last_rise    = 0;
    int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
    int ferr_run = 0, ovr_run = 0, perr_run = 0;
    int flag_max_run = 0;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.m_valid) valid_cycles++;
            if (m_if.m_valid && !valid_prev) last_rise = cyc;
            if (m_if.m_valid && m_if.m_ready) got_q.push_back(m_if.m_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            ferr_run = frame_err ? ferr_run + 1 : 0;
            ovr_run  = overrun ? ovr_run + 1 : 0;
`ifdef UART_RX_PARITY_EN
            if (parity_err) perr_cnt++;
            perr_run = parity_err ? perr_run + 1 : 0;
`endif
            if (ferr_run > flag_max_run) flag_max_run = ferr_run;
            if (ovr_run > flag_max_run) flag_max_run = ovr_run;
            if (perr_run > flag_max_run) flag_max_run = perr_run;
        end
        valid_prev = m_if.m_valid;
    end

    // ---------------- scoreboard / checks ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    int start_cyc = 0;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR) drive_bit(par_bit);
        drive_bit(stop_bit);
        rxd = 1'b1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    int a0, f0, o0, v0, lat;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        rxd = 1'b1;
        m_if.m_ready = 1'b1;
        idle(10);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        check("reset_valid", {31'd0, m_if.m_valid}, 32'd0);
        check("reset_data", {24'd0, m_if.m_data}, 32'd0);
        check("reset_flags", {30'd0, frame_err, overrun}, 32'd0);
        rst_n = 1'b1;
        idle(20);

        // Table: single frames with m_ready held high.
        for (int i = 0; i < 7; i++) begin
            a0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
            send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
            idle(2 * BIT);
            check($sformatf("vec%0d_count", i), got_q.size() - a0, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_valid_cycles", i), valid_cycles - v0, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d_overrun", i), ovr_cnt - o0, 32'd0);
            if (vecs[i].exp_valid && got_q.size() > a0) begin
                check($sformatf("vec%0d_data", i), {24'd0, got_q[a0]}, {24'd0, vecs[i].data});
                lat = last_rise - start_cyc;
                n_cmp++;
                if (lat < 1216 || lat > 1224) begin
                    n_fail++;
                    $display("FAIL vec%0d_latency: got %0d clk, expected 1216..1224", i, lat);
                end
            end
        end

        // Glitch: 30 clk low pulse (200 clk scaled by 8/54).
        a0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        @(posedge clk); #1;
        rxd = 1'b0;
        idle(20);
        check("glitch_entered_start", {29'd0, dbg_state}, 32'd1);
        idle(10);
        rxd = 1'b1;
        idle(42);
        check("glitch_back_idle", {29'd0, dbg_state}, 32'd0);
        idle(2 * BIT);
        check("glitch_no_byte", got_q.size() - a0, 32'd0);
        check("glitch_no_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);

        // Overrun: two bytes with the consumer stalled.
        m_if.m_ready = 1'b0;
        a0 = got_q.size(); o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, ^8'h11);
        idle(16);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(2 * BIT);
        check("ovr_pulse", ovr_cnt - o0, 32'd1);
        check("ovr_data_held", {24'd0, m_if.m_data}, 32'h11);
        check("ovr_valid_held", {31'd0, m_if.m_valid}, 32'd1);
        m_if.m_ready = 1'b1;
        idle(2 * BIT);
        check("ovr_drain_count", got_q.size() - a0, 32'd1);
        if (got_q.size() > a0) check("ovr_drain_data", {24'd0, got_q[a0]}, 32'h11);
        check("ovr_valid_clear", {31'd0, m_if.m_valid}, 32'd0);

        // New byte loads on the very edge the old one is accepted.
        m_if.m_ready = 1'b0;
        a0 = got_q.size(); o0 = ovr_cnt;
        send_frame(8'h33, 1'b1, ^8'h33);
        idle(16);
        fork
            send_frame(8'h44, 1'b1, ^8'h44);
            begin
                @(posedge clk); #1;
                repeat (1218) @(posedge clk);
                #1;
                m_if.m_ready = 1'b1;
                @(posedge clk); #1;
                m_if.m_ready = 1'b0;
            end
        join
        idle(BIT);
        check("same_edge_valid", {31'd0, m_if.m_valid}, 32'd1);
        m_if.m_ready = 1'b1;
        idle(2 * BIT);
        exp_q = '{8'h33, 8'h44};
        check("same_edge_count", got_q.size() - a0, 32'd2);
        for (int k = 0; k < 2; k++)
            if (got_q.size() > a0 + k)
                check($sformatf("same_edge_data%0d", k), {24'd0, got_q[a0+k]}, {24'd0, exp_q[k]});
        check("same_edge_no_overrun", ovr_cnt - o0, 32'd0);

        // Reset during data bit 4 of an 8'h00 frame.
        fork
            send_frame(8'h00, 1'b1, 1'b0);
            begin
                @(posedge clk); #1;
                repeat (BIT * 5 + 64) @(posedge clk);
                #1;
                rst_n = 1'b0;
                idle(4);
                check("midrst_state", {29'd0, dbg_state}, 32'd0);
                check("midrst_valid", {31'd0, m_if.m_valid}, 32'd0);
                check("midrst_data", {24'd0, m_if.m_data}, 32'd0);
                check("midrst_flags", {30'd0, frame_err, overrun}, 32'd0);
                idle(16);
                rst_n = 1'b1;
            end
        join
        a0 = got_q.size();
        idle(2 * BIT);
        check("midrst_no_residue", got_q.size() - a0, 32'd0);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        idle(2 * BIT);
        check("midrst_next_count", got_q.size() - a0, 32'd1);
        if (got_q.size() > a0) check("midrst_next_data", {24'd0, got_q[a0]}, 32'hFF);

`ifdef UART_RX_PARITY_EN
        a0 = got_q.size(); f0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2 * BIT);
        check("par_bad_pulse", perr_cnt - f0, 32'd1);
        check("par_bad_no_byte", got_q.size() - a0, 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * BIT);
        check("par_good_count", got_q.size() - a0, 32'd1);
        if (got_q.size() > a0) check("par_good_data", {24'd0, got_q[a0]}, 32'h07);
`endif

        check("flag_pulse_width", flag_max_run, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 Port clk  input  1  is the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port rxd  input  1  is the serial line, asynchronous to clk, idle high.
REQ-006 Port m_data  output  8  is the received byte.
REQ-007 Port m_valid  output  1  is high while m_data holds an unconsumed byte.
REQ-008 Port m_ready  input  1  is the consumer acceptance; a transfer occurs when m_valid and m_ready are both high at a clk edge.
REQ-009 Port frame_err  output  1  SHALL pulse for one cycle when a stop bit samples low.
REQ-010 Port overrun  output  1  SHALL pulse for one cycle when a byte is dropped because the holding register is full.

Function
REQ-011 rxd SHALL pass through a two-flop synchronizer, reset to 1, before any use.
REQ-012 A tick counter SHALL produce one tick every DIV = CLK_HZ/(BAUD*16) clocks, truncated to an integer (54 with defaults). The counter SHALL restart at 0 on every frame start.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when REQ-026 applies.
REQ-014 IDLE -> START SHALL occur only on a 1->0 transition of the synchronized line. A line held low SHALL NOT retrigger.
REQ-015 In START, the line SHALL be sampled after 8 ticks (mid-bit). Low -> DATA. High -> IDLE as a glitch, with no output and no flag.
REQ-016 DATA SHALL sample every 16 ticks, 8 bits, LSB first, into a shift register.
REQ-017 STOP SHALL sample after 16 ticks and then always return to IDLE.
REQ-018 On a high stop bit, m_data and m_valid SHALL be loaded on the clock after the sample, giving a latency of 1 clk from the stop-bit midpoint.
REQ-019 On a low stop bit, frame_err SHALL pulse, the byte SHALL be discarded, and m_valid/m_data SHALL be unchanged.
REQ-020 m_valid and m_data SHALL stay stable until the handshake completes. m_valid SHALL clear on the handshake edge unless a new byte loads on that same edge.
REQ-021 Byte completes with m_valid=1 and m_ready=0: the new byte SHALL be dropped, the old byte retained, and overrun pulsed.
REQ-022 Byte completes on the same edge as a handshake: the new byte SHALL load, m_valid SHALL remain 1, and there SHALL be no overrun.
REQ-023 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-024 While rst_n=0, the block SHALL set: FSM=IDLE, counters=0, synchronizer=1, m_data=8'h00, m_valid=0, frame_err=0, overrun=0 (and parity_err=0 when REQ-026 applies).
REQ-025 Reset mid-frame SHALL abandon the frame with no output. After release, the next frame SHALL require a fresh 1->0 edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN, when defined, SHALL:
- add state PARITY between DATA and STOP, sampled after 16 ticks;
- check even parity over the 8 data bits plus the parity bit;
- add port parity_err  output  1, which pulses for one cycle on mismatch, at the cycle the stop bit is evaluated;
- on mismatch, discard the byte as in REQ-019, independently of frame_err.
REQ-027 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, and neither the parity_err port nor the PARITY state SHALL exist.

Verification
(Defaults: 1 bit = 864 clk.)
REQ-028 Send 8'hA5 8N1 with m_ready=1: m_valid SHALL pulse 1 cycle with m_data=8'hA5 about 9.5 bit times after the start edge. No flags.
REQ-029 Pulse rxd low for 200 clk, then return high: no m_valid, no flags, and the FSM SHALL be back in IDLE before 432 clk.
REQ-030 Send 8'h3C with the stop bit forced low: frame_err SHALL pulse once, m_valid SHALL stay 0, and a following 8'h55 SHALL be received correctly.
REQ-031 With m_ready=0, send 8'h11 then 8'h22: m_data SHALL be 8'h11 and overrun SHALL pulse once. Raising m_ready SHALL then yield only 8'h11.
REQ-032 Assert rst_n=0 during data bit 4 of a frame: all outputs SHALL be 0. After release, the partial frame's residue SHALL produce no byte, and the next full 8'hFF SHALL be received.
REQ-033 With UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 (wrong; correct is 1): parity_err SHALL pulse and no m_valid. The same byte with parity bit 1 SHALL be received.
